// File: rtl/nios2_debug_cmd_sync.sv
// JTAG debug command synchroniser: brings update-DR/IR strobes into the clk domain,
// queues them as commands and decodes popped DR commands into action pulses.
module nios2_debug_cmd_sync #(
    parameter int DATA_W      = 38,
    parameter int IR_W        = 2,
    parameter int SYNC_STAGES = 2,
    parameter int FIFO_DEPTH  = 4,
    localparam int NACT       = 2 ** IR_W,
    localparam int CNT_W      = $clog2(FIFO_DEPTH + 1)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              vs_udr,
    input  logic              vs_uir,
    input  logic [IR_W-1:0]   ir_in,
    input  logic [DATA_W-1:0] sr,
    input  logic              cmd_ready,
    input  logic              clear_overflow,
    output logic              cmd_valid,
    output logic              cmd_is_ir,
    output logic [IR_W-1:0]   cmd_ir,
    output logic [DATA_W-1:0] jdo,
    output logic [NACT-1:0]   take_action,
    output logic [NACT-1:0]   take_no_action,
    output logic [CNT_W-1:0]  fifo_count,
    output logic              overflow
);

    localparam int PTR_W   = $clog2(FIFO_DEPTH);
    localparam int ENTRY_W = 1 + IR_W + DATA_W;

    logic [SYNC_STAGES-1:0] udr_sync_q, udr_sync_d, uir_sync_q, uir_sync_d, fill_q, fill_d;
    logic                   udr_prev_q, udr_prev_d, uir_prev_q, uir_prev_d;
    logic                   udr_arm_q, udr_arm_d, uir_arm_q, uir_arm_d;
    logic                   udr_evt_q, udr_evt_d, uir_evt_q, uir_evt_d;
    logic                   pend_valid_q, pend_valid_d;
    logic [ENTRY_W-1:0]     pend_entry_q, pend_entry_d;
    logic [ENTRY_W-1:0]     mem_q [FIFO_DEPTH];
    logic [ENTRY_W-1:0]     mem_d [FIFO_DEPTH];
    logic [PTR_W-1:0]       wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CNT_W-1:0]       count_q, count_d;
    logic                   overflow_q, overflow_d;
    logic [DATA_W-1:0]      jdo_q, jdo_d;
    logic [NACT-1:0]        take_action_q, take_action_d, take_no_action_q, take_no_action_d;

    logic                   push, push_ok, pop, full, drop;
    logic [ENTRY_W-1:0]     push_entry, head, dr_entry, ir_entry;
    logic [IR_W-1:0]        head_ir;

    assign dr_entry  = {1'b0, ir_in, sr};
    assign ir_entry  = {1'b1, ir_in, {DATA_W{1'b0}}};
    assign head      = mem_q[rptr_q];
    assign head_ir   = head[DATA_W +: IR_W];
    assign full      = (count_q == CNT_W'(FIFO_DEPTH));
    assign pop       = cmd_valid & cmd_ready;

    assign cmd_valid      = (count_q != '0);
    assign cmd_is_ir      = cmd_valid & head[ENTRY_W-1];
    assign cmd_ir         = cmd_valid ? head_ir : '0;
    assign jdo            = jdo_q;
    assign take_action    = take_action_q;
    assign take_no_action = take_no_action_q;
    assign fifo_count     = count_q;
    assign overflow       = overflow_q;

    always_comb begin
        // fill_q marks when the synchroniser outputs reflect post-reset samples;
        // a strobe is armed only after it has been seen low, so a level held high
        // through reset release does not look like a rising edge.
        fill_d     = {fill_q[SYNC_STAGES-2:0], 1'b1};
        udr_sync_d = {udr_sync_q[SYNC_STAGES-2:0], vs_udr};
        uir_sync_d = {uir_sync_q[SYNC_STAGES-2:0], vs_uir};
        udr_prev_d = udr_sync_q[SYNC_STAGES-1];
        uir_prev_d = uir_sync_q[SYNC_STAGES-1];
        udr_arm_d  = udr_arm_q | (fill_q[SYNC_STAGES-1] & ~udr_sync_q[SYNC_STAGES-1]);
        uir_arm_d  = uir_arm_q | (fill_q[SYNC_STAGES-1] & ~uir_sync_q[SYNC_STAGES-1]);
        udr_evt_d  = udr_sync_q[SYNC_STAGES-1] & ~udr_prev_q & udr_arm_q;
        uir_evt_d  = uir_sync_q[SYNC_STAGES-1] & ~uir_prev_q & uir_arm_q;

        push         = 1'b0;
        push_entry   = '0;
        pend_valid_d = 1'b0;
        pend_entry_d = pend_entry_q;
        if (pend_valid_q) begin
            push       = 1'b1;
            push_entry = pend_entry_q;
            if (udr_evt_q) begin
                pend_valid_d = 1'b1;
                pend_entry_d = dr_entry;
            end else if (uir_evt_q) begin
                pend_valid_d = 1'b1;
                pend_entry_d = ir_entry;
            end
        end else if (udr_evt_q) begin
            push       = 1'b1;
            push_entry = dr_entry;
            if (uir_evt_q) begin
                pend_valid_d = 1'b1;
                pend_entry_d = ir_entry;
            end
        end else if (uir_evt_q) begin
            push       = 1'b1;
            push_entry = ir_entry;
        end

        // A pop in the same cycle frees the slot the write lands in.
        push_ok = push & (~full | pop);
        drop    = push & full & ~pop;

        mem_d  = mem_q;
        wptr_d = wptr_q;
        if (push_ok) begin
            mem_d[wptr_q] = push_entry;
            wptr_d        = wptr_q + 1'b1;
        end
        rptr_d  = pop ? rptr_q + 1'b1 : rptr_q;
        count_d = count_q;
        if (push_ok && !pop) begin
            count_d = count_q + 1'b1;
        end else if (pop && !push_ok) begin
            count_d = count_q - 1'b1;
        end
        overflow_d = drop | (overflow_q & ~clear_overflow);

        jdo_d            = jdo_q;
        take_action_d    = '0;
        take_no_action_d = '0;
        if (pop && !head[ENTRY_W-1]) begin
            jdo_d = head[DATA_W-1:0];
            if (head[DATA_W-1]) begin
                take_action_d[head_ir] = 1'b1;
            end else begin
                take_no_action_d[head_ir] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fill_q           <= '0;
            udr_sync_q       <= '0;
            uir_sync_q       <= '0;
            udr_prev_q       <= 1'b0;
            uir_prev_q       <= 1'b0;
            udr_arm_q        <= 1'b0;
            uir_arm_q        <= 1'b0;
            udr_evt_q        <= 1'b0;
            uir_evt_q        <= 1'b0;
            pend_valid_q     <= 1'b0;
            pend_entry_q     <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wptr_q           <= '0;
            rptr_q           <= '0;
            count_q          <= '0;
            overflow_q       <= 1'b0;
            jdo_q            <= '0;
            take_action_q    <= '0;
            take_no_action_q <= '0;
        end else begin
            fill_q           <= fill_d;
            udr_sync_q       <= udr_sync_d;
            uir_sync_q       <= uir_sync_d;
            udr_prev_q       <= udr_prev_d;
            uir_prev_q       <= uir_prev_d;
            udr_arm_q        <= udr_arm_d;
            uir_arm_q        <= uir_arm_d;
            udr_evt_q        <= udr_evt_d;
            uir_evt_q        <= uir_evt_d;
            pend_valid_q     <= pend_valid_d;
            pend_entry_q     <= pend_entry_d;
            mem_q            <= mem_d;
            wptr_q           <= wptr_d;
            rptr_q           <= rptr_d;
            count_q          <= count_d;
            overflow_q       <= overflow_d;
            jdo_q            <= jdo_d;
            take_action_q    <= take_action_d;
            take_no_action_q <= take_no_action_d;
        end
    end

endmodule

// File: doc/nios2_debug_cmd_sync.md
# nios2_debug_cmd_sync

Parametrised JTAG-debug command synchroniser for the Nios II debug slave, clocked in the CPU system-clock domain. It brings the virtual-JTAG update strobes (update-DR, update-IR) and their shift-register and IR contents into the system clock domain and queues each as a command in a small FIFO. It releases commands through a valid/ready handshake and decodes each popped command into one-hot take_action / take_no_action pulses. It replaces the fixed 38-bit, 2-bit-IR, unbuffered sysclk stage with configurable widths, sync depth, buffering and overflow reporting.

## Interface
- DATA_W, 38: width of the captured shift register and of jdo; must be ≥2.
- IR_W, 2: virtual IR width; number of action channels is 2**IR_W.
- SYNC_STAGES, 2: synchroniser flops per strobe; must be ≥2.
- FIFO_DEPTH, 4: command queue depth; must be a power of 2 and ≥2.

- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- vs_udr  in  1  update-DR level from the JTAG domain; asynchronous to clk.
- vs_uir  in  1  update-IR level from the JTAG domain; asynchronous to clk.
- ir_in  in  IR_W  virtual IR; stable from ≥1 tck before a strobe until the next shift.
- sr  in  DATA_W  shift-register contents; stable under the same rule as ir_in.
- cmd_ready  in  1  consumer accepts the head command.
- clear_overflow  in  1  single-cycle clear of the overflow flag.
- cmd_valid  out  1  FIFO head is valid.
- cmd_is_ir  out  1  head entry came from update-IR (1) or update-DR (0).
- cmd_ir  out  IR_W  IR value captured with the head entry.
- jdo  out  DATA_W  data of the most recently popped DR command.
- take_action  out  2**IR_W  one-hot, one-cycle pulse on pop of a DR command with action bit 1.
- take_no_action  out  2**IR_W  one-hot, one-cycle pulse on pop of a DR command with action bit 0.
- fifo_count  out  $clog2(FIFO_DEPTH+1)  number of occupied entries.
- overflow  out  1  sticky flag; set when a command is dropped.

## Operation
- Each strobe passes through SYNC_STAGES flops plus one edge-detect flop. A synchronised rising edge produces a one-cycle event. Falling edges are ignored.
- DR event: sample sr and ir_in in the event cycle and push the entry {is_ir=0, ir_in, sr}.
- IR event: push the entry {is_ir=1, ir_in, data=0}.
- Simultaneous DR and IR events in the same cycle: push the DR entry first. Park the IR entry in a one-entry pending register and push it on the next cycle. The pending register has priority over any new event on that cycle.
- FIFO: single write port, registered head. A pop occurs when cmd_valid and cmd_ready are both 1.
- Push when full is dropped unless a pop happens in the same cycle, in which case the push is accepted. A dropped push sets overflow.
- Push and pop in the same cycle leave fifo_count unchanged. Read and write pointers wrap modulo FIFO_DEPTH.
- On pop of a DR entry:
  - jdo is updated with its data on the next cycle.
  - The action bit is data[DATA_W-1].
  - take_action[cmd_ir] pulses if the action bit is 1; take_no_action[cmd_ir] pulses if it is 0.
  - The pulse occurs in the cycle after the pop.
- On pop of an IR entry: jdo holds its value and no pulse is issued.
- clear_overflow clears overflow on the next edge. If a drop occurs in the same cycle, set wins.
- Reset: all synchronisers, pointers and the pending register clear. All outputs reset to 0: cmd_valid, cmd_is_ir, cmd_ir, jdo, take_action, take_no_action, fifo_count, overflow. A strobe level that is high at reset release does not produce an event until it falls and rises again. Entries in flight are lost, with no overflow indication.

## Timing
- The strobe-to-event latency is SYNC_STAGES+1 clk edges after the input rises.
- The event-to-cmd_valid latency is 1 cycle when the FIFO is empty.
- The pop-to-pulse latency is 1 cycle. jdo updates on that same edge.
- Throughput is one push and one pop per cycle.
- Strobe pulses narrower than 2 clk periods are not guaranteed to be captured. The JTAG side guarantees ≥2 tck periods with tck ≤ clk/2.
- take_action and take_no_action are never both nonzero in one cycle, and each has at most one bit set.

## Test plan
- Reset with vs_udr held high, then release: no event occurs and every output stays 0. Drop vs_udr, then raise it with ir_in=2 and sr MSB=1: cmd_valid rises 4 cycles later (SYNC_STAGES=2). With cmd_ready=1, take_action=4'b0100 pulses one cycle after the pop and jdo equals sr.
- DR command with sr MSB=0 and ir_in=0: take_no_action=4'b0001 pulses and take_action stays 0.
- Five DR strobes with cmd_ready=0 (DEPTH=4): fifo_count=4 and overflow=1. Draining returns the first four sr values in order. clear_overflow then clears the flag.
- Full FIFO with cmd_ready=1 in the same cycle as a new event: no drop occurs, overflow stays 0 and fifo_count stays 4.
- vs_udr and vs_uir rise together: the DR entry is queued before the IR entry. The IR pop sets cmd_is_ir=1 and issues no action pulse.
- reset_n asserted while 3 entries are queued: all outputs are 0 asynchronously. After release, fifo_count=0.
